// File: rtl/datapath_multiciclo_pkg.sv
// Shared encodings for the multi-cycle RV datapath: FSM states, ALU and
// writeback selectors, opcode/funct3 constants and the branch resolver.
package datapath_multiciclo_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WRITEBACK,
    S_HALT
  } state_t;

  localparam logic [1:0] ULA_ADD = 2'b00;
  localparam logic [1:0] ULA_SUB = 2'b01;
  localparam logic [1:0] ULA_SLT = 2'b10;
  localparam logic [1:0] ULA_EQU = 2'b11;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;
  localparam logic [1:0] WB_NONE = 2'b11;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [31:0] EBREAK = 32'h00100073;

  // Odd funct3 codes (bne/bge/bgeu) take the branch on the inverted compare.
  function automatic logic branch_taken(input logic [2:0] funct3, input logic cmp);
    return funct3[0] ? ~cmp : cmp;
  endfunction

endpackage

// File: rtl/datapath_multiciclo_if.sv
// Instruction/data memory request-ready bus between the datapath (master)
// and the external memories (slave).
interface datapath_multiciclo_if #(
  parameter int XLEN = 64
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [31:0]     imem_rdata;
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_ready;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_ready, imem_rdata, dmem_ready, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_ready, imem_rdata, dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/datapath_multiciclo_banco_reg.sv
// 32 x XLEN register file: two asynchronous read ports, one synchronous
// write port, x0 hardwired to zero, synchronous active-low clear.
module banco_reg_param #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  logic [XLEN-1:0] regs [32];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && wa != 5'd0) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];

endmodule

// File: rtl/datapath_multiciclo.sv
// Multi-cycle RV datapath: FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencing with
// handshaked instruction/data memories and an external combinational control unit.
module datapath_multiciclo
  import datapath_multiciclo_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_en,
  input  logic                  store_en,
  input  logic [1:0]            op_ula,
  input  logic [1:0]            operation_type,
  input  logic                  ula_entry,
  input  logic                  branch,
  input  logic                  auipc,
  input  logic                  jal,
  input  logic                  jalr,
  input  logic                  sign,
  datapath_multiciclo_if.master bus,
  output logic [XLEN-1:0]       program_counter,
  output logic [31:0]           instru,
  output logic                  overflow,
  output logic                  halted
);

  state_t          state;
  logic [XLEN-1:0] pc, a, b, imm, aluout, mdr;
  logic [31:0]     ri;
  logic            taken, imem_req_q, dmem_req_q, dmem_we_q, ovf_q, halted_q;

  logic [XLEN-1:0] rd1, rd2, rf_wd;
  logic            rf_we;
  logic [4:0]      rd;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'(signed'(v));
  endfunction

  function automatic logic add_sub_ovf(input logic sub, input logic a_msb,
                                       input logic b_msb, input logic r_msb);
    return sub ? ((a_msb != b_msb) && (r_msb != a_msb))
               : ((a_msb == b_msb) && (r_msb != a_msb));
  endfunction

  assign rd = ri[11:7];

  banco_reg_param #(.XLEN(XLEN)) u_rf (
    .clk  (clk),
    .reset(reset),
    .we   (rf_we),
    .wa   (rd),
    .wd   (rf_wd),
    .ra1  (ri[19:15]),
    .ra2  (ri[24:20]),
    .rd1  (rd1),
    .rd2  (rd2)
  );

  // Immediate format is chosen from the opcode in ri, since the control
  // inputs are not trusted until EXECUTE.
  logic [31:0] imm32;
  always_comb begin
    imm32 = {{20{ri[31]}}, ri[31:20]};
    case (ri[6:0])
      OPC_STORE:          imm32 = {{20{ri[31]}}, ri[31:25], ri[11:7]};
      OPC_BRANCH:         imm32 = {{19{ri[31]}}, ri[31], ri[7], ri[30:25], ri[11:8], 1'b0};
      OPC_JAL:            imm32 = {{11{ri[31]}}, ri[31], ri[19:12], ri[20], ri[30:21], 1'b0};
      OPC_LUI, OPC_AUIPC: imm32 = {ri[31:12], 12'b0};
      default:            imm32 = {{20{ri[31]}}, ri[31:20]};
    endcase
  end

  logic [XLEN-1:0]        src_a, src_b, alu_res;
  logic signed [XLEN-1:0] sa, sb;
  logic                   alu_ovf;
  always_comb begin
    src_a   = auipc ? pc : a;
    src_b   = ula_entry ? b : imm;
    sa      = src_a;
    sb      = src_b;
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op_ula)
      ULA_ADD: begin
        alu_res = src_a + src_b;
        alu_ovf = add_sub_ovf(1'b0, src_a[XLEN-1], src_b[XLEN-1], alu_res[XLEN-1]);
      end
      ULA_SUB: begin
        alu_res = src_a - src_b;
        alu_ovf = add_sub_ovf(1'b1, src_a[XLEN-1], src_b[XLEN-1], alu_res[XLEN-1]);
      end
      ULA_SLT: alu_res = {{(XLEN-1){1'b0}}, sign ? (sa < sb) : (src_a < src_b)};
      default: alu_res = {{(XLEN-1){1'b0}}, src_a == src_b};
    endcase
  end

  logic [XLEN-1:0] pc_plus4, pc_target, jalr_sum, pc_next;
  always_comb begin
    pc_plus4  = pc + XLEN'(4);
    pc_target = pc + imm;
    jalr_sum  = a + imm;
    if (jal)        pc_next = pc_target;
    else if (jalr)  pc_next = {jalr_sum[XLEN-1:1], 1'b0};
    else if (taken) pc_next = pc_target;
    else            pc_next = pc_plus4;

    case (operation_type)
      WB_MEM:  rf_wd = mdr;
      WB_PC4:  rf_wd = pc_plus4;
      default: rf_wd = aluout;
    endcase
    rf_we = (state == S_WRITEBACK) && load_en && (operation_type != WB_NONE) && (rd != 5'd0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      ri         <= '0;
      a          <= '0;
      b          <= '0;
      imm        <= '0;
      aluout     <= '0;
      mdr        <= '0;
      taken      <= 1'b0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      ovf_q      <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      case (state)
        // FETCH: raise the request once after reset, then hold until ready
        S_FETCH: begin
          if (!imem_req_q) begin
            imem_req_q <= 1'b1;
          end else if (bus.imem_ready) begin
            ri         <= bus.imem_rdata;
            imem_req_q <= 1'b0;
            state      <= S_DECODE;
          end
        end
        // DECODE
        S_DECODE: begin
          a   <= rd1;
          b   <= rd2;
          imm <= sext32(imm32);
          if (ri == 32'd0 || ri == EBREAK) begin
            state    <= S_HALT;
            halted_q <= 1'b1;
          end else begin
            state <= S_EXECUTE;
          end
        end
        // EXECUTE
        S_EXECUTE: begin
          aluout <= alu_res;
          if (!op_ula[1]) ovf_q <= alu_ovf;
          taken <= branch && branch_taken(ri[14:12], alu_res[0]);
          if ((load_en && operation_type == WB_MEM) || store_en) begin
            dmem_req_q <= 1'b1;
            dmem_we_q  <= store_en;
            state      <= S_MEM;
          end else begin
            state <= S_WRITEBACK;
          end
        end
        // MEM: a store retires here, a load continues to WRITEBACK
        S_MEM: begin
          if (bus.dmem_ready) begin
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            if (dmem_we_q) begin
              pc         <= pc_next;
              imem_req_q <= 1'b1;
              state      <= S_FETCH;
            end else begin
              mdr   <= bus.dmem_rdata;
              state <= S_WRITEBACK;
            end
          end
        end
        // WRITEBACK
        S_WRITEBACK: begin
          pc         <= pc_next;
          imem_req_q <= 1'b1;
          state      <= S_FETCH;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

  assign bus.imem_req     = imem_req_q;
  assign bus.imem_addr    = pc;
  assign bus.dmem_req     = dmem_req_q;
  assign bus.dmem_we      = dmem_we_q;
  assign bus.dmem_addr    = aluout;
  assign bus.dmem_wdata   = b;
  assign program_counter  = pc;
  assign instru           = ri;
  assign overflow         = ovf_q;
  assign halted           = halted_q;

endmodule

// File: tb/tb_datapath_multiciclo.sv
// Directed bench for datapath_multiciclo: small program in a word-addressed
// instruction memory, a data memory with programmable wait states, and a
// combinational control-unit model decoding instru.
module tb_datapath_multiciclo;
  import datapath_multiciclo_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_en, store_en, ula_entry, branch, auipc, jal, jalr, sign;
  logic [1:0]  op_ula, operation_type;
  logic [63:0] program_counter;
  logic [31:0] instru;
  logic        overflow, halted;

  int checks = 0;
  int errors = 0;
  int dwait  = 0;
  int dcnt   = 0;

  logic [31:0] imem [1024];
  logic [63:0] dmem [64];

  datapath_multiciclo_if #(.XLEN(64)) bus ();

  datapath_multiciclo #(.XLEN(64), .RESET_PC(64'h0)) dut (
    .clk            (clk),
    .reset          (reset),
    .load_en        (load_en),
    .store_en       (store_en),
    .op_ula         (op_ula),
    .operation_type (operation_type),
    .ula_entry      (ula_entry),
    .branch         (branch),
    .auipc          (auipc),
    .jal            (jal),
    .jalr           (jalr),
    .sign           (sign),
    .bus            (bus),
    .program_counter(program_counter),
    .instru         (instru),
    .overflow       (overflow),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  // Control unit model
  always_comb begin
    load_en = 1'b0; store_en = 1'b0; ula_entry = 1'b0; branch = 1'b0;
    auipc = 1'b0; jal = 1'b0; jalr = 1'b0; sign = 1'b0;
    op_ula = ULA_ADD; operation_type = WB_ALU;
    case (instru[6:0])
      OPC_OPIMM: load_en = 1'b1;
      OPC_OP: begin
        load_en = 1'b1; ula_entry = 1'b1;
        op_ula = instru[30] ? ULA_SUB : ULA_ADD;
      end
      OPC_LOAD:  begin load_en = 1'b1; operation_type = WB_MEM; end
      OPC_STORE: begin store_en = 1'b1; operation_type = WB_NONE; end
      OPC_BRANCH: begin
        branch = 1'b1; ula_entry = 1'b1; operation_type = WB_NONE;
        op_ula = instru[14] ? ULA_SLT : ULA_EQU;
        sign = ~instru[13];
      end
      OPC_JAL:   begin jal = 1'b1; load_en = 1'b1; operation_type = WB_PC4; end
      OPC_JALR:  begin jalr = 1'b1; load_en = 1'b1; operation_type = WB_PC4; end
      OPC_AUIPC: begin auipc = 1'b1; load_en = 1'b1; end
      default: ;
    endcase
  end

  // Memories: zero-wait instruction fetch, data side waits dwait cycles.
  // The word at 0x10 is a read-only constant.
  always_comb begin
    bus.imem_ready = bus.imem_req;
    bus.imem_rdata = imem[bus.imem_addr[11:2]];
    bus.dmem_ready = bus.dmem_req && (dcnt >= dwait);
    bus.dmem_rdata = (bus.dmem_addr == 64'h10) ? 64'h7FFF_FFFF_FFFF_FFFF
                                               : dmem[bus.dmem_addr[8:3]];
  end

  always @(posedge clk) begin
    dcnt <= (bus.dmem_req && !bus.dmem_ready) ? dcnt + 1 : 0;
    if (bus.dmem_req && bus.dmem_we && bus.dmem_ready)
      dmem[bus.dmem_addr[8:3]] <= bus.dmem_wdata;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for the pc to leave its current value, then checks the new one.
  task automatic next_pc(input string tag, input logic [63:0] exp);
    logic [63:0] start;
    int n;
    start = program_counter;
    n = 0;
    while (program_counter === start && n < 40) begin tick(1); n++; end
    chk(tag, program_counter, exp);
  endtask

  task automatic wait_halt(input string tag);
    int n;
    n = 0;
    while (halted !== 1'b1 && n < 40) begin tick(1); n++; end
    chk(tag, {63'd0, halted}, 64'd1);
  endtask

  task automatic put(input int addr, input logic [31:0] word);
    imem[addr >> 2] = word;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 1024; i++) imem[i] = 32'h0;
    put('h000, 32'h00500093);  // addi x1,x0,5
    put('h004, 32'h00103423);  // sd   x1,8(x0)
    put('h008, 32'h00803103);  // ld   x2,8(x0)
    put('h00C, 32'h00500193);  // addi x3,x0,5
    put('h010, 32'h0100006F);  // jal  x0,+16
    put('h020, 32'h00308863);  // beq  x1,x3,+16
    put('h030, 32'h0D00006F);  // jal  x0,+0xD0
    put('h100, 32'h001000EF);  // jal  x1,+2048
    put('h900, 32'h00108067);  // jalr x0,1(x1)
    put('h104, 32'h01003283);  // ld   x5,16(x0)
    put('h108, 32'h00100313);  // addi x6,x0,1
    put('h10C, 32'h00628233);  // add  x4,x5,x6
    put('h110, 32'h00700013);  // addi x0,x0,7
    put('h114, 32'hF2DFF06F);  // jal  x0,-212
    put('h040, EBREAK);

    reset = 1'b0;
    tick(2);
    chk("rst_pc", program_counter, 64'h0);
    chk("rst_ri", {32'd0, instru}, 64'h0);
    chk("rst_imem_req", {63'd0, bus.imem_req}, 64'd0);
    chk("rst_dmem_req", {63'd0, bus.dmem_req}, 64'd0);
    chk("rst_halted", {63'd0, halted}, 64'd0);
    chk("rst_ovf", {63'd0, overflow}, 64'd0);
    reset = 1'b1;

    tick(1);
    chk("fetch_req", {63'd0, bus.imem_req}, 64'd1);
    chk("fetch_addr", bus.imem_addr, 64'h0);
    tick(1);
    chk("ri_addi", {32'd0, instru}, 64'h00500093);
    tick(2);
    chk("addi_pc_early", program_counter, 64'h0);
    tick(1);
    chk("addi_x1", dut.u_rf.regs[1], 64'd5);
    chk("addi_pc", program_counter, 64'h4);

    tick(3);
    chk("sd_req", {63'd0, bus.dmem_req}, 64'd1);
    chk("sd_we", {63'd0, bus.dmem_we}, 64'd1);
    chk("sd_addr", bus.dmem_addr, 64'h8);
    chk("sd_wdata", bus.dmem_wdata, 64'd5);
    tick(1);
    chk("sd_pc", program_counter, 64'h8);
    chk("sd_mem", dmem[1], 64'd5);
    dwait = 3;

    tick(3);
    chk("ld_req", {63'd0, bus.dmem_req}, 64'd1);
    chk("ld_we", {63'd0, bus.dmem_we}, 64'd0);
    chk("ld_addr", bus.dmem_addr, 64'h8);
    for (int k = 0; k < 2; k++) begin
      tick(1);
      chk("ld_wait_req", {63'd0, bus.dmem_req}, 64'd1);
      chk("ld_wait_addr", bus.dmem_addr, 64'h8);
    end
    tick(2);
    chk("ld_pc_early", program_counter, 64'h8);
    tick(1);
    chk("ld_x2", dut.u_rf.regs[2], 64'd5);
    chk("ld_pc", program_counter, 64'hC);
    dwait = 0;

    next_pc("addi_x3_pc", 64'h10);
    next_pc("jal_fwd_pc", 64'h20);
    next_pc("beq_taken_pc", 64'h30);
    next_pc("jal_far_pc", 64'h100);
    next_pc("jal_link_pc", 64'h900);
    chk("jal_link_x1", dut.u_rf.regs[1], 64'h104);
    next_pc("jalr_pc", 64'h104);
    next_pc("ld_x5_pc", 64'h108);
    next_pc("addi_x6_pc", 64'h10C);
    next_pc("add_pc", 64'h110);
    chk("add_x4", dut.u_rf.regs[4], 64'h8000_0000_0000_0000);
    chk("add_ovf", {63'd0, overflow}, 64'd1);
    next_pc("addi_x0_pc", 64'h114);
    chk("x0_zero", dut.u_rf.regs[0], 64'h0);
    chk("addi_ovf_clr", {63'd0, overflow}, 64'd0);
    next_pc("jal_back_pc", 64'h40);
    wait_halt("ebreak_halt");
    tick(3);
    chk("halt_pc", program_counter, 64'h40);
    chk("halt_imem_req", {63'd0, bus.imem_req}, 64'd0);
    chk("halt_dmem_req", {63'd0, bus.dmem_req}, 64'd0);

    // Reset out of HALT, then reset again while a store is pending.
    put('h020, 32'h00309863);  // bne x1,x3,+16
    dwait = 1000;
    reset = 1'b0;
    tick(1);
    chk("rst2_halted", {63'd0, halted}, 64'd0);
    chk("rst2_pc", program_counter, 64'h0);
    chk("rst2_x1", dut.u_rf.regs[1], 64'h0);
    reset = 1'b1;
    n = 0;
    while (bus.dmem_req !== 1'b1 && n < 40) begin tick(1); n++; end
    tick(3);
    chk("pend_req", {63'd0, bus.dmem_req}, 64'd1);
    chk("pend_addr", bus.dmem_addr, 64'h8);
    reset = 1'b0;
    tick(1);
    chk("pend_rst_dreq", {63'd0, bus.dmem_req}, 64'd0);
    chk("pend_rst_ireq", {63'd0, bus.imem_req}, 64'd0);
    chk("pend_rst_pc", program_counter, 64'h0);
    reset = 1'b1;
    dwait = 0;

    next_pc("r3_addi_pc", 64'h4);
    next_pc("r3_sd_pc", 64'h8);
    next_pc("r3_ld_pc", 64'hC);
    next_pc("r3_addi_x3_pc", 64'h10);
    next_pc("r3_jal_pc", 64'h20);
    next_pc("bne_not_taken_pc", 64'h24);
    wait_halt("zero_word_halt");
    chk("zero_halt_pc", program_counter, 64'h24);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
